// File: rtl/key_debounce_encoder.sv
// Keypad front end: synchronises and debounces the 12 raw key lines, rejects chords,
// and emits one coded key event per press plus a long-hold pulse.
module key_debounce_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 50,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] Key,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic        key_long,
    output logic        multi_err
);

    localparam int unsigned KEY_W  = 12;
    localparam int unsigned CODE_W = 4;
    localparam logic [CNT_W-1:0]  DB_LIMIT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  HOLD_LIMIT = CNT_W'(HOLD_CYCLES);
    localparam logic [CODE_W-1:0] NO_KEY     = 4'hF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    sync1_q, sync1_d;
    logic [KEY_W-1:0]    sync2_q, sync2_d;
    logic [KEY_W-1:0]    candidate_q, candidate_d;
    logic [CNT_W-1:0]    db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                long_done_q, long_done_d;
    logic                key_valid_q, key_valid_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_held_q, key_held_d;
    logic                key_long_q, key_long_d;
    logic                multi_err_q, multi_err_d;

    logic                is_zero;
    logic                is_onehot;
    logic                is_multi;
    logic                same_key;
    logic [CNT_W-1:0]    db_inc;
    logic [CNT_W-1:0]    hold_inc;

    // One-hot key line to keypad code; only ever called with a one-hot value.
    function automatic logic [CODE_W-1:0] encode(input logic [KEY_W-1:0] k);
        logic [CODE_W-1:0] c;
        case (k)
            12'h001: c = 4'h1;
            12'h002: c = 4'h2;
            12'h004: c = 4'h3;
            12'h008: c = 4'h4;
            12'h010: c = 4'h5;
            12'h020: c = 4'h6;
            12'h040: c = 4'h7;
            12'h080: c = 4'h8;
            12'h100: c = 4'h9;
            12'h200: c = 4'hB;
            12'h400: c = 4'h0;
            12'h800: c = 4'hA;
            default: c = NO_KEY;
        endcase
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            candidate_q <= '0;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= NO_KEY;
            key_held_q  <= 1'b0;
            key_long_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            candidate_q <= candidate_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            key_long_q  <= key_long_d;
            multi_err_q <= multi_err_d;
        end
    end

    always_comb begin
        is_zero   = (sync2_q == '0);
        is_onehot = !is_zero && ((sync2_q & (sync2_q - KEY_W'(1))) == '0);
        is_multi  = !is_zero && !is_onehot;
        same_key  = (sync2_q == candidate_q);
        db_inc    = db_cnt_q + CNT_W'(1);
        hold_inc  = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

        state_d     = state_q;
        sync1_d     = Key;
        sync2_d     = sync1_q;
        candidate_d = candidate_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_long_d  = 1'b0;
        multi_err_d = is_multi;

        case (state_q)
            IDLE: begin
                if (is_onehot) begin
                    state_d     = DB_PRESS;
                    candidate_d = sync2_q;
                    db_cnt_d    = CNT_W'(1);
                end
            end
            DB_PRESS: begin
                if (same_key) begin
                    db_cnt_d = db_inc;
                    if (db_inc == DB_LIMIT) begin
                        state_d     = PRESSED;
                        key_valid_d = 1'b1;
                        key_code_d  = encode(candidate_q);
                        hold_cnt_d  = '0;
                        long_done_d = 1'b0;
                    end
                end else if (is_onehot) begin
                    candidate_d = sync2_q;
                    db_cnt_d    = CNT_W'(1);
                end else begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (same_key) begin
                    hold_cnt_d = hold_inc;
                    if (hold_inc == HOLD_LIMIT && !long_done_q) begin
                        key_long_d  = 1'b1;
                        long_done_d = 1'b1;
                    end
                end else begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = is_zero ? CNT_W'(1) : '0;
                end
            end
            DB_RELEASE: begin
                // A different key or chord restarts the release count; no rollover.
                if (is_zero) begin
                    db_cnt_d = db_inc;
                    if (db_inc == DB_LIMIT) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end
                end else if (same_key) begin
                    state_d = PRESSED;
                end else begin
                    db_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        key_held_d = (state_d == PRESSED) || (state_d == DB_RELEASE);
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign key_long  = key_long_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder: press latency, bounce, sequences,
// chords, long hold and reset in mid-press.
module tb_key_debounce_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] Key;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        key_long;
    logic        multi_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int valid_cnt = 0;
    int long_cnt = 0;
    int held_cnt = 0;
    int multi_cnt = 0;
    int last_valid_cyc = -1;
    int last_long_cyc = -1;
    logic [3:0] last_code = 4'h0;
    logic [3:0] codes[$];

    key_debounce_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .Key       (Key),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .key_long  (key_long),
        .multi_err (multi_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observation of outputs on the falling edge; cyc is the last rising edge number.
    always @(negedge clock) begin
        if (key_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_code = key_code;
            codes.push_back(key_code);
        end
        if (key_long === 1'b1) begin
            long_cnt++;
            last_long_cyc = cyc;
        end
        if (key_held === 1'b1) held_cnt++;
        if (multi_err === 1'b1) multi_cnt++;
    end

    task automatic clear_obs();
        valid_cnt = 0;
        long_cnt = 0;
        held_cnt = 0;
        multi_cnt = 0;
        last_valid_cyc = -1;
        last_long_cyc = -1;
        codes.delete();
    endtask

    // Drive v so that exactly n rising edges sample it; first_edge is the first of them.
    task automatic set_key(input logic [11:0] v, input int n, output int first_edge);
        @(posedge clock);
        #1;
        Key = v;
        first_edge = cyc + 1;
        repeat (n - 1) @(posedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Key = 12'h000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL reset_code: got %h expected f", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (key_long !== 1'b0) begin errors++; $display("FAIL reset_long: got %b expected 0", key_long); end
        checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b expected 0", multi_err); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_basic_press();
        int k, r;
        clear_obs();
        set_key(12'h002, 10, k);
        set_key(12'h000, 20, r);
        @(negedge clock);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL basic_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (last_valid_cyc != k + 5) begin errors++; $display("FAIL basic_latency: got edge %0d expected %0d", last_valid_cyc, k + 5); end
        checks++; if (last_code !== 4'h2) begin errors++; $display("FAIL basic_code: got %h expected 2", last_code); end
        checks++; if (held_cnt != 10) begin errors++; $display("FAIL basic_held_cycles: got %0d expected 10", held_cnt); end
        checks++; if (long_cnt != 0) begin errors++; $display("FAIL basic_no_long: got %0d expected 0", long_cnt); end
        checks++; if (key_code !== 4'h2 || key_held !== 1'b0) begin errors++; $display("FAIL basic_after_release: got code %h held %b expected 2 0", key_code, key_held); end
    endtask

    task automatic test_bounce();
        int k, d;
        clear_obs();
        for (int i = 0; i < 6; i++) set_key((i % 2 == 0) ? 12'h008 : 12'h000, 1, d);
        set_key(12'h008, 10, k);
        set_key(12'h000, 20, d);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL bounce_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (last_valid_cyc != k + 5) begin errors++; $display("FAIL bounce_latency: got edge %0d expected %0d", last_valid_cyc, k + 5); end
        checks++; if (last_code !== 4'h4) begin errors++; $display("FAIL bounce_code: got %h expected 4", last_code); end
    endtask

    task automatic test_sequence();
        logic [11:0] keys[5] = '{12'h002, 12'h008, 12'h004, 12'h004, 12'h200};
        logic [3:0]  exp[5]  = '{4'h2, 4'h4, 4'h3, 4'h3, 4'hB};
        int d;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            set_key(keys[i], 10, d);
            set_key(12'h000, 10, d);
        end
        set_key(12'h000, 10, d);
        checks++; if (codes.size() != 5) begin errors++; $display("FAIL seq_count: got %0d expected 5", codes.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < codes.size()) begin
                checks++; if (codes[i] !== exp[i]) begin errors++; $display("FAIL seq_code[%0d]: got %h expected %h", i, codes[i], exp[i]); end
            end
        end
    endtask

    task automatic test_chord();
        int d;
        clear_obs();
        set_key(12'h005, 10, d);
        set_key(12'h000, 15, d);
        @(negedge clock);
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL chord_no_valid: got %0d expected 0", valid_cnt); end
        checks++; if (multi_cnt != 10) begin errors++; $display("FAIL chord_multi_cycles: got %0d expected 10", multi_cnt); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL chord_held: got %b expected 0", key_held); end

        clear_obs();
        set_key(12'h001, 10, d);
        set_key(12'h801, 10, d);
        set_key(12'h800, 10, d);
        @(negedge clock);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rollover_held: got %b expected 1", key_held); end
        set_key(12'h000, 15, d);
        @(negedge clock);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL rollover_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (last_code !== 4'h1) begin errors++; $display("FAIL rollover_code: got %h expected 1", last_code); end
        checks++; if (multi_cnt != 10) begin errors++; $display("FAIL rollover_multi_cycles: got %0d expected 10", multi_cnt); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rollover_release: got %b expected 0", key_held); end
    endtask

    task automatic test_long_hold();
        int k, d;
        clear_obs();
        set_key(12'h200, 70, k);
        set_key(12'h000, 20, d);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL long_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (last_valid_cyc != k + 5) begin errors++; $display("FAIL long_valid_edge: got %0d expected %0d", last_valid_cyc, k + 5); end
        checks++; if (last_code !== 4'hB) begin errors++; $display("FAIL long_code: got %h expected b", last_code); end
        checks++; if (long_cnt != 1) begin errors++; $display("FAIL long_cnt: got %0d expected 1", long_cnt); end
        checks++; if (last_long_cyc != k + 55) begin errors++; $display("FAIL long_edge: got %0d expected %0d", last_long_cyc, k + 55); end
    endtask

    task automatic test_long_glitch();
        int k, d;
        clear_obs();
        set_key(12'h200, 20, k);
        set_key(12'h000, 1, d);
        set_key(12'h200, 60, d);
        set_key(12'h000, 1, d);
        set_key(12'h200, 10, d);
        set_key(12'h000, 20, d);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL glitch_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (long_cnt != 1) begin errors++; $display("FAIL glitch_long_cnt: got %0d expected 1", long_cnt); end
        checks++; if (last_long_cyc != k + 57) begin errors++; $display("FAIL glitch_long_edge: got %0d expected %0d", last_long_cyc, k + 57); end
    endtask

    task automatic test_reset_mid_press();
        int k, n, d;
        set_key(12'h020, 10, k);
        clear_obs();
        @(posedge clock);
        #1;
        reset = 1'b0;
        n = cyc + 1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", key_valid); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL midrst_code: got %h expected f", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b expected 0", key_held); end
        checks++; if (key_long !== 1'b0) begin errors++; $display("FAIL midrst_long: got %b expected 0", key_long); end
        checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL midrst_multi: got %b expected 0", multi_err); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clock);
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL midrst_valid_cnt: got %0d expected 1", valid_cnt); end
        checks++; if (last_valid_cyc != n + 7) begin errors++; $display("FAIL midrst_latency: got edge %0d expected %0d", last_valid_cyc, n + 7); end
        checks++; if (last_code !== 4'h6) begin errors++; $display("FAIL midrst_code_after: got %h expected 6", last_code); end
        set_key(12'h000, 20, d);
    endtask

    initial begin
        Key = 12'h000;
        reset = 1'b0;
        test_reset();
        test_basic_press();
        test_bounce();
        test_sequence();
        test_chord();
        test_long_hold();
        test_long_glitch();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
